mcp3008_responder: RTL and testbench



---
 rtl/mcp3008_pkg.sv | 26 ++
 rtl/mcp3008_responder_sig_sync.sv | 35 +++
 rtl/mcp3008_responder.sv | 188 ++++++++++++++++++
 tb/tb_mcp3008_responder.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mcp3008_pkg.sv
// Shared types and constants for the MCP3008 SPI slave model.
//   state_t  : frame FSM states
//   ADC_W    : sample width in bits
//   NUM_CH   : number of channel registers
//   diff_sel : partner channel of a differential pair
package mcp3008_pkg;

  localparam int unsigned ADC_W  = 10;
  localparam int unsigned NUM_CH = 8;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_START,
    CMD,
    NULL_WAIT,
    MSB,
    LSB,
    TAIL
  } state_t;

  // Differential pairs are (0,1), (2,3), (4,5), (6,7); in- is the other half.
  function automatic logic [2:0] diff_sel(input logic [2:0] sel);
    return sel ^ 3'b001;
  endfunction

endpackage

// File: rtl/mcp3008_responder_sig_sync.sv
// N-flop synchronizer with registered one-cycle edge strobes.
//   clk, rst_n : system clock, async active-low reset
//   d          : asynchronous input
//   rise, fall : one-clk strobes for rising/falling edges of the synced input
module sig_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;
  logic              synced;

  assign synced = chain[STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
      prev  <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      prev  <= synced;
      rise  <= synced & ~prev;
      fall  <= ~synced & prev;
    end
  end

endmodule

// File: rtl/mcp3008_responder.sv
// Cycle-accurate MCP3008 SPI slave serving samples from host channel registers.
//   clk, rst_n          : system clock, async active-low reset
//   ad_clk, cs, din     : SPI from the master (asynchronous to clk)
//   dout, dout_oe       : serial result and frame-active enable
//   ch_data             : eight 10-bit channel values, CHi at [10*i +: 10]
//   conv_valid          : one-clk pulse when a conversion is latched
//   conv_ch, conv_sgl   : command fields of the latched conversion
//   conv_data           : latched result
module mcp3008_responder
  import mcp3008_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ad_clk,
  input  logic                     cs,
  input  logic                     din,
  output logic                     dout,
  output logic                     dout_oe,
  input  logic [ADC_W*NUM_CH-1:0]  ch_data,
  output logic                     conv_valid,
  output logic [2:0]               conv_ch,
  output logic                     conv_sgl,
  output logic [ADC_W-1:0]         conv_data
);

  logic rise, fall;

  sig_sync #(.STAGES(SYNC_STAGES)) u_clk_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ad_clk),
    .rise  (rise),
    .fall  (fall)
  );

  logic [SYNC_STAGES-1:0] cs_pipe, din_pipe;
  logic cs_s, din_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_pipe  <= '1;
      din_pipe <= '0;
    end else begin
      cs_pipe  <= {cs_pipe[SYNC_STAGES-2:0], cs};
      din_pipe <= {din_pipe[SYNC_STAGES-2:0], din};
    end
  end

  assign cs_s  = cs_pipe[SYNC_STAGES-1];
  assign din_s = din_pipe[SYNC_STAGES-1];

  // Result arithmetic
  logic [ADC_W-1:0] ch_arr [NUM_CH];
  logic [ADC_W-1:0] pos, neg, result;
  logic signed [ADC_W:0] diff;

  state_t           state, state_n;
  logic [3:0]       cmd, cmd_n;
  logic [ADC_W-1:0] shreg, shreg_n;
  logic [3:0]       cnt, cnt_n;
  logic             dout_n, oe_n, cv_n, csgl_n;
  logic [2:0]       cch_n;
  logic [ADC_W-1:0] cdata_n;

  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      ch_arr[i] = ch_data[ADC_W*i +: ADC_W];
    end
    pos  = ch_arr[cmd[2:0]];
    neg  = ch_arr[diff_sel(cmd[2:0])];
    diff = $signed({1'b0, pos}) - $signed({1'b0, neg});
    if (cmd[3]) begin
      result = pos;
    end else if (diff[ADC_W]) begin
      result = '0;
    end else begin
      result = diff[ADC_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cmd        <= '0;
      shreg      <= '0;
      cnt        <= '0;
      dout       <= 1'b0;
      dout_oe    <= 1'b0;
      conv_valid <= 1'b0;
      conv_ch    <= '0;
      conv_sgl   <= 1'b0;
      conv_data  <= '0;
    end else begin
      state      <= state_n;
      cmd        <= cmd_n;
      shreg      <= shreg_n;
      cnt        <= cnt_n;
      dout       <= dout_n;
      dout_oe    <= oe_n;
      conv_valid <= cv_n;
      conv_ch    <= cch_n;
      conv_sgl   <= csgl_n;
      conv_data  <= cdata_n;
    end
  end

  always_comb begin
    state_n = state;
    cmd_n   = cmd;
    shreg_n = shreg;
    cnt_n   = cnt;
    dout_n  = dout;
    oe_n    = dout_oe;
    cv_n    = 1'b0;
    cch_n   = conv_ch;
    csgl_n  = conv_sgl;
    cdata_n = conv_data;

    // cs deassertion overrides any strobe arriving in the same cycle.
    if (cs_s) begin
      state_n = IDLE;
      dout_n  = 1'b0;
      oe_n    = 1'b0;
    end else begin
      unique case (state)
        IDLE: state_n = WAIT_START;
        WAIT_START: begin
          if (rise && din_s) begin
            state_n = CMD;
            oe_n    = 1'b1;
            cnt_n   = '0;
          end
        end
        CMD: begin
          if (rise) begin
            cmd_n = {cmd[2:0], din_s};
            cnt_n = cnt + 4'd1;
            if (cnt == 4'd3) state_n = NULL_WAIT;
          end
        end
        NULL_WAIT: begin
          if (fall) begin
            shreg_n = result;
            cdata_n = result;
            cch_n   = cmd[2:0];
            csgl_n  = cmd[3];
            cv_n    = 1'b1;
            dout_n  = 1'b0;
            cnt_n   = '0;
            state_n = MSB;
          end
        end
        // Rotating rather than shifting leaves the word intact after B0,
        // so the LSB-first pass can rotate back the other way.
        MSB: begin
          if (fall) begin
            dout_n  = shreg[ADC_W-1];
            shreg_n = {shreg[ADC_W-2:0], shreg[ADC_W-1]};
            if (cnt == 4'd9) begin
              cnt_n   = '0;
              state_n = LSB;
            end else begin
              cnt_n = cnt + 4'd1;
            end
          end
        end
        LSB: begin
          if (fall) begin
            dout_n  = shreg[1];
            shreg_n = {shreg[0], shreg[ADC_W-1:1]};
            if (cnt == 4'd8) begin
              state_n = TAIL;
            end else begin
              cnt_n = cnt + 4'd1;
            end
          end
        end
        TAIL: begin
          if (fall) dout_n = 1'b0;
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mcp3008_responder.sv
// Directed bench for mcp3008_responder: SPI master at ad_clk = clk/54.
module tb_mcp3008_responder;

  localparam int unsigned SYNC = 2;
  localparam int HALF = 27;

  logic        clk = 1'b0;
  logic        rst_n, ad_clk, cs, din;
  logic        dout, dout_oe, conv_valid, conv_sgl;
  logic [2:0]  conv_ch;
  logic [9:0]  conv_data;
  logic [79:0] ch_data;

  int n_total = 0;
  int n_bad   = 0;
  int cv_total = 0;
  bit zap = 1'b0;

  mcp3008_responder #(.SYNC_STAGES(SYNC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ad_clk     (ad_clk),
    .cs         (cs),
    .din        (din),
    .dout       (dout),
    .dout_oe    (dout_oe),
    .ch_data    (ch_data),
    .conv_valid (conv_valid),
    .conv_ch    (conv_ch),
    .conv_sgl   (conv_sgl),
    .conv_data  (conv_data)
  );

  always #10 clk = ~clk;

  always @(negedge clk) if (conv_valid === 1'b1) cv_total++;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", tag, got, exp);
    end
  endtask

  // One ad_clk period, mode 0,0: drive din, low half, rise (sample), high half, fall.
  task automatic spi_bit(input logic b, output logic s);
    din = b;
    for (int i = 0; i < HALF; i++) begin
      @(posedge clk); #1;
      if (zap && conv_valid) begin
        @(posedge clk); #1;
        ch_data[50 +: 10] = '0;
        zap = 1'b0;
      end
    end
    ad_clk = 1'b1;
    s = dout;
    repeat (HALF) begin @(posedge clk); #1; end
    ad_clk = 1'b0;
  endtask

  task automatic send_cmd(input int nlead, input logic sgl, input logic [2:0] ch);
    logic s;
    cs = 1'b0;
    repeat (HALF) begin @(posedge clk); #1; end
    for (int i = 0; i < nlead; i++) spi_bit(1'b0, s);
    spi_bit(1'b1, s);
    spi_bit(sgl, s);
    spi_bit(ch[2], s);
    spi_bit(ch[1], s);
    spi_bit(ch[0], s);
  endtask

  task automatic read_result(output logic nul, output logic [9:0] msb,
                             output logic [8:0] lsb, output logic tail);
    logic s;
    msb = '0; lsb = '0; tail = 1'b0;
    spi_bit(1'b0, nul);
    for (int i = 0; i < 10; i++) begin spi_bit(1'b0, s); msb = {msb[8:0], s}; end
    for (int i = 0; i < 9; i++)  begin spi_bit(1'b0, s); lsb = {lsb[7:0], s}; end
    for (int i = 0; i < 2; i++)  begin spi_bit(1'b0, s); tail = tail | s; end
  endtask

  task automatic end_frame();
    cs = 1'b1;
    repeat (SYNC + 3) begin @(posedge clk); #1; end
  endtask

  logic       nul, tail, s;
  logic [9:0] msb;
  logic [8:0] lsb;
  int         cv0;

  initial begin
    rst_n = 1'b0; cs = 1'b1; ad_clk = 1'b0; din = 1'b0;
    ch_data = '0;
    ch_data[50 +: 10] = 10'h2A5;
    ch_data[20 +: 10] = 10'd300;
    ch_data[30 +: 10] = 10'd100;
    ch_data[0  +: 10] = 10'h3FF;
    repeat (4) begin @(posedge clk); #1; end
    check_val("rst_dout", dout, 0);
    check_val("rst_oe", dout_oe, 0);
    check_val("rst_cv", conv_valid, 0);
    check_val("rst_ch", conv_ch, 0);
    check_val("rst_sgl", conv_sgl, 0);
    check_val("rst_data", conv_data, 0);
    rst_n = 1'b1;
    repeat (4) begin @(posedge clk); #1; end

    // Single-ended CH5, seven leading zeros
    cv0 = cv_total;
    send_cmd(7, 1'b1, 3'd5);
    read_result(nul, msb, lsb, tail);
    check_val("f1_null", nul, 0);
    check_val("f1_msb", msb, 10'h2A5);
    check_val("f1_lsb", lsb, 9'b010010101);
    check_val("f1_tail", tail, 0);
    check_val("f1_oe_on", dout_oe, 1);
    end_frame();
    check_val("f1_oe_off", dout_oe, 0);
    check_val("f1_dout_off", dout, 0);
    check_val("f1_cv_cnt", cv_total - cv0, 1);
    check_val("f1_ch", conv_ch, 5);
    check_val("f1_sgl", conv_sgl, 1);
    check_val("f1_data", conv_data, 10'h2A5);

    // Differential 2-3 = 200
    cv0 = cv_total;
    send_cmd(2, 1'b0, 3'd2);
    read_result(nul, msb, lsb, tail);
    check_val("d2_msb", msb, 10'h0C8);
    check_val("d2_lsb", lsb, 9'b001001100);
    end_frame();
    check_val("d2_sgl", conv_sgl, 0);
    check_val("d2_ch", conv_ch, 2);
    check_val("d2_data", conv_data, 10'h0C8);

    // Differential 3-2 clamps to 0
    send_cmd(0, 1'b0, 3'd3);
    read_result(nul, msb, lsb, tail);
    check_val("d3_msb", msb, 10'h000);
    end_frame();
    check_val("d3_data", conv_data, 10'h000);
    check_val("d_cv_cnt", cv_total - cv0, 2);

    // Abort after D1 captured
    cv0 = cv_total;
    cs = 1'b0;
    repeat (HALF) begin @(posedge clk); #1; end
    spi_bit(1'b1, s); spi_bit(1'b1, s); spi_bit(1'b0, s); spi_bit(1'b0, s);
    repeat (8) begin @(posedge clk); #1; end
    check_val("ab_oe_on", dout_oe, 1);
    cs = 1'b1;
    repeat (SYNC + 1) begin @(posedge clk); #1; end
    check_val("ab_oe_off", dout_oe, 0);
    repeat (60) begin @(posedge clk); #1; end
    check_val("ab_cv_cnt", cv_total - cv0, 0);
    send_cmd(1, 1'b1, 3'd0);
    read_result(nul, msb, lsb, tail);
    check_val("ab_next_msb", msb, 10'h3FF);
    check_val("ab_next_lsb", lsb, 9'h1FF);
    end_frame();
    check_val("ab_next_data", conv_data, 10'h3FF);
    check_val("ab_next_cv", cv_total - cv0, 1);

    // Async reset during MSB bit 4
    send_cmd(2, 1'b1, 3'd5);
    spi_bit(1'b0, s);
    for (int i = 0; i < 4; i++) spi_bit(1'b0, s);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #2;
    check_val("ar_dout", dout, 0);
    check_val("ar_oe", dout_oe, 0);
    check_val("ar_cv", conv_valid, 0);
    check_val("ar_ch", conv_ch, 0);
    check_val("ar_sgl", conv_sgl, 0);
    check_val("ar_data", conv_data, 0);
    cs = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    cv0 = cv_total;
    send_cmd(3, 1'b1, 3'd5);
    read_result(nul, msb, lsb, tail);
    check_val("ar_msb", msb, 10'h2A5);
    end_frame();
    check_val("ar_data2", conv_data, 10'h2A5);
    check_val("ar_cv_cnt", cv_total - cv0, 1);

    // CH5 cleared one cycle after conv_valid: frame in flight still 2A5
    zap = 1'b1;
    send_cmd(2, 1'b1, 3'd5);
    read_result(nul, msb, lsb, tail);
    check_val("zap_msb", msb, 10'h2A5);
    check_val("zap_lsb", lsb, 9'b010010101);
    check_val("zap_cleared", ch_data[50 +: 10], 10'h000);
    end_frame();
    check_val("zap_data", conv_data, 10'h2A5);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
